// File: rtl/mem_access.sv
// Memory-access stage: issues one DCache request per load/store, aligns load data, registers the WB result.
// Optional macro MEM_LOAD_BYPASS_EN muxes the response-cycle load data straight to WB/forwarding.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        advance,
  output logic        advance_ready,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_store_data,
  input  logic        ex_excp,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_waddr,
  input  logic [31:0] ex_wdata,
  output logic        dcache_req_valid,
  input  logic        dcache_req_ready,
  output logic        dcache_req_we,
  output logic [31:0] dcache_req_addr,
  output logic [3:0]  dcache_req_wstrb,
  output logic [31:0] dcache_req_wdata,
  input  logic        dcache_resp_valid,
  input  logic [31:0] dcache_resp_data,
  output logic        wb_valid,
  output logic        wb_wreg,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        fwd_valid,
  output logic        fwd_data_valid,
  output logic [4:0]  fwd_waddr,
  output logic [31:0] fwd_wdata
);

`ifdef MEM_LOAD_BYPASS_EN
  localparam logic BYPASS = 1'b1;
`else
  localparam logic BYPASS = 1'b0;
`endif

  // Handshake: a request transfers on a cycle where dcache_req_valid and
  // dcache_req_ready are both high; once raised, valid and all request fields
  // stay stable until that cycle (the EX buffer is held by advance_ready = 0).
  typedef enum logic [2:0] {IDLE, REQ, WAIT_RESP, DONE, DRAIN} state_t;
  state_t state;

  logic        mem_op;
  logic        req_fire;
  logic        store_acc;
  logic        load_acc;
  logic        resp_now;
  logic        load_avail;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_aligned;
  logic [31:0] load_hold;
  logic [31:0] load_data;
  logic [31:0] result;
  logic [3:0]  wstrb;
  logic [31:0] wdata_rep;

  assign mem_op    = ex_valid & (ex_load | ex_store) & ~ex_excp;
  // Flush withdraws an unaccepted request so nothing is issued for a dead instruction.
  assign dcache_req_valid = mem_op & ((state == IDLE) | (state == REQ)) & ~flush;
  assign req_fire  = dcache_req_valid & dcache_req_ready;
  assign store_acc = req_fire & ex_store;
  assign load_acc  = req_fire & ~ex_store;
  assign resp_now  = (state == WAIT_RESP) & dcache_resp_valid;

  always_comb begin
    wstrb     = 4'hF;
    wdata_rep = ex_store_data;
    case (ex_size)
      2'd0: begin
        wstrb     = 4'b0001 << ex_addr[1:0];
        wdata_rep = {4{ex_store_data[7:0]}};
      end
      2'd1: begin
        wstrb     = 4'b0011 << {ex_addr[1], 1'b0};
        wdata_rep = {2{ex_store_data[15:0]}};
      end
      default: begin
        wstrb     = 4'hF;
        wdata_rep = ex_store_data;
      end
    endcase
  end

  assign dcache_req_we    = dcache_req_valid & ex_store;
  assign dcache_req_addr  = dcache_req_valid ? {ex_addr[31:2], 2'b00} : 32'h0;
  assign dcache_req_wstrb = dcache_req_we ? wstrb : 4'h0;
  assign dcache_req_wdata = dcache_req_we ? wdata_rep : 32'h0;

  assign byte_sel = dcache_resp_data[{ex_addr[1:0], 3'b000} +: 8];
  assign half_sel = ex_addr[1] ? dcache_resp_data[31:16] : dcache_resp_data[15:0];

  always_comb begin
    load_aligned = dcache_resp_data;
    case (ex_size)
      2'd0:    load_aligned = {{24{~ex_unsigned & byte_sel[7]}}, byte_sel};
      2'd1:    load_aligned = {{16{~ex_unsigned & half_sel[15]}}, half_sel};
      default: load_aligned = dcache_resp_data;
    endcase
  end

  assign load_data  = (BYPASS & resp_now) ? load_aligned : load_hold;
  assign load_avail = (state == DONE) | (BYPASS & resp_now);
  assign result     = (ex_load & ~ex_excp) ? load_data : ex_wdata;

  assign advance_ready = (state != DRAIN) &
                         (~mem_op | (state == DONE) | store_acc | (BYPASS & resp_now));

  assign fwd_valid      = ex_valid & ex_wreg;
  assign fwd_data_valid = ~ex_load | ex_excp | load_avail;
  assign fwd_waddr      = ex_waddr;
  assign fwd_wdata      = result;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      load_hold <= 32'h0;
      wb_valid  <= 1'b0;
      wb_wreg   <= 1'b0;
      wb_waddr  <= 5'h0;
      wb_wdata  <= 32'h0;
    end else begin
      if (resp_now) load_hold <= load_aligned;

      if (flush) begin
        wb_valid <= 1'b0;
        wb_wreg  <= 1'b0;
        wb_waddr <= 5'h0;
        wb_wdata <= 32'h0;
      end else if (advance) begin
        wb_valid <= ex_valid;
        wb_wreg  <= ex_wreg & ~ex_excp;
        wb_waddr <= ex_waddr;
        wb_wdata <= result;
      end

      case (state)
        IDLE, REQ: begin
          if (flush)          state <= IDLE;
          else if (store_acc) state <= advance ? IDLE : DONE;
          else if (load_acc)  state <= WAIT_RESP;
          else if (mem_op)    state <= REQ;
          else                state <= IDLE;
        end
        WAIT_RESP: begin
          if (dcache_resp_valid) begin
            if (flush | (BYPASS & advance)) state <= IDLE;
            else                            state <= DONE;
          end else if (flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          if (flush | advance) state <= IDLE;
        end
        DRAIN: begin
          // The late response belongs to a flushed load and is dropped.
          if (dcache_resp_valid) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: table of single-cycle vectors plus directed multi-cycle load/store/flush sequences.
module tb_mem_access;

`ifdef MEM_LOAD_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        advance;
  logic        advance_ready;
  logic        ex_valid;
  logic        ex_load;
  logic        ex_store;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr;
  logic [31:0] ex_store_data;
  logic        ex_excp;
  logic        ex_wreg;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        dcache_req_valid;
  logic        dcache_req_ready;
  logic        dcache_req_we;
  logic [31:0] dcache_req_addr;
  logic [3:0]  dcache_req_wstrb;
  logic [31:0] dcache_req_wdata;
  logic        dcache_resp_valid;
  logic [31:0] dcache_resp_data;
  logic        wb_valid;
  logic        wb_wreg;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        fwd_valid;
  logic        fwd_data_valid;
  logic [4:0]  fwd_waddr;
  logic [31:0] fwd_wdata;

  int n_vec = 0;
  int n_err = 0;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush), .advance(advance), .advance_ready(advance_ready),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
    .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_store_data(ex_store_data),
    .ex_excp(ex_excp), .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .dcache_req_valid(dcache_req_valid), .dcache_req_ready(dcache_req_ready),
    .dcache_req_we(dcache_req_we), .dcache_req_addr(dcache_req_addr),
    .dcache_req_wstrb(dcache_req_wstrb), .dcache_req_wdata(dcache_req_wdata),
    .dcache_resp_valid(dcache_resp_valid), .dcache_resp_data(dcache_resp_data),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .fwd_valid(fwd_valid), .fwd_data_valid(fwd_data_valid), .fwd_waddr(fwd_waddr),
    .fwd_wdata(fwd_wdata)
  );

  // Clock and reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        excp;
    logic        wreg;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic        e_wb_wreg;
    logic [31:0] e_wb_wdata;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd0; ex_unsigned = 1'b0;
    ex_addr = 32'h0; ex_store_data = 32'h0; ex_excp = 1'b0; ex_wreg = 1'b0;
    ex_waddr = 5'd0; ex_wdata = 32'h0; advance = 1'b0; flush = 1'b0;
    dcache_req_ready = 1'b1; dcache_resp_valid = 1'b0; dcache_resp_data = 32'h0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [4:0] waddr);
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = size; ex_unsigned = uns;
    ex_addr = addr; ex_store_data = 32'h0; ex_excp = 1'b0; ex_wreg = 1'b1;
    ex_waddr = waddr; ex_wdata = 32'hFFFF_FFFF; advance = 1'b0; flush = 1'b0;
    dcache_req_ready = 1'b1;
  endtask

  // Called at posedge+1 of the issue cycle; response arrives 'delay' cycles after acceptance.
  task automatic wait_load_done(input string name, input int delay, input logic [31:0] resp,
                                input logic [31:0] exp_wb, input logic [4:0] exp_waddr);
    int stall;
    stall = -1;
    for (int c = 0; c < 20; c++) begin
      dcache_resp_valid = (c == delay);
      dcache_resp_data  = resp;
      @(negedge clk);
      if (c == 0) begin
        check({name, "_req_valid"}, dcache_req_valid, 1'b1);
        check({name, "_fwd_dv_wait"}, fwd_data_valid, 1'b0);
      end
      if (advance_ready) begin
        stall = c;
        advance = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    advance = 1'b0; ex_valid = 1'b0; dcache_resp_valid = 1'b0;
    check({name, "_stall"}, stall, (BYP != 0) ? delay : delay + 1);
    @(negedge clk);
    check({name, "_wb_valid"}, wb_valid, 1'b1);
    check({name, "_wb_wreg"}, wb_wreg, 1'b1);
    check({name, "_wb_waddr"}, wb_waddr, exp_waddr);
    check({name, "_wb_wdata"}, wb_wdata, exp_wb);
    @(posedge clk); #1;
  endtask

  initial begin
    drive_idle();
    rst = 1'b1;
    //         ld  st  sz    addr          sdata         ex  wr  wa     wdata         req  e_addr        strb     e_wdata       wbwr wb_wdata
    vecs[0] = '{1'b0, 1'b1, 2'd0, 32'h0000_2001, 32'h0000_00A5, 1'b0, 1'b0, 5'd0, 32'h11,
                1'b1, 32'h0000_2000, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h11};
    vecs[1] = '{1'b0, 1'b1, 2'd1, 32'h0000_2002, 32'h1234_BEEF, 1'b0, 1'b0, 5'd0, 32'h22,
                1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h22};
    vecs[2] = '{1'b0, 1'b1, 2'd2, 32'h0000_3008, 32'hCAFE_F00D, 1'b0, 1'b0, 5'd0, 32'h33,
                1'b1, 32'h0000_3008, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h33};
    vecs[3] = '{1'b0, 1'b1, 2'd0, 32'h0000_3003, 32'h0000_007E, 1'b0, 1'b0, 5'd0, 32'h44,
                1'b1, 32'h0000_3000, 4'b1000, 32'h7E7E_7E7E, 1'b0, 32'h44};
    vecs[4] = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 5'd5, 32'h1234,
                1'b0, 32'h0, 4'b0000, 32'h0, 1'b1, 32'h1234};
    vecs[5] = '{1'b1, 1'b0, 2'd2, 32'h0000_0010, 32'h0000_0000, 1'b1, 1'b1, 5'd7, 32'hDEAD,
                1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 32'hDEAD};
    vecs[6] = '{1'b0, 1'b1, 2'd0, 32'h0000_0020, 32'h0000_00FF, 1'b1, 1'b0, 5'd2, 32'h55,
                1'b0, 32'h0, 4'b0000, 32'h0, 1'b0, 32'h55};
    vecs[7] = '{1'b0, 1'b1, 2'd1, 32'h0000_4000, 32'hFFFF_8001, 1'b0, 1'b0, 5'd0, 32'h66,
                1'b1, 32'h0000_4000, 4'b0011, 32'h8001_8001, 1'b0, 32'h66};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_wreg", wb_wreg, 1'b0);
    check("rst_wb_waddr", wb_waddr, 5'd0);
    check("rst_wb_wdata", wb_wdata, 32'h0);
    check("rst_req_valid", dcache_req_valid, 1'b0);
    check("rst_req_addr", dcache_req_addr, 32'h0);
    check("rst_adv_ready", advance_ready, 1'b1);
    @(posedge clk); #1;

    // Single-cycle vectors: stores with ready high, non-memory ops, excepted ops.
    for (int i = 0; i < 8; i++) begin
      ex_valid = 1'b1; ex_load = vecs[i].ld; ex_store = vecs[i].st; ex_size = vecs[i].size;
      ex_unsigned = 1'b0; ex_addr = vecs[i].addr; ex_store_data = vecs[i].sdata;
      ex_excp = vecs[i].excp; ex_wreg = vecs[i].wreg; ex_waddr = vecs[i].waddr;
      ex_wdata = vecs[i].wdata; advance = 1'b1; dcache_req_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_req_valid", i), dcache_req_valid, vecs[i].e_req);
      check($sformatf("v%0d_req_we", i), dcache_req_we, vecs[i].e_req & vecs[i].st);
      check($sformatf("v%0d_req_addr", i), dcache_req_addr, vecs[i].e_addr);
      check($sformatf("v%0d_req_wstrb", i), dcache_req_wstrb, vecs[i].e_strb);
      check($sformatf("v%0d_req_wdata", i), dcache_req_wdata, vecs[i].e_wdata);
      check($sformatf("v%0d_adv_ready", i), advance_ready, 1'b1);
      check($sformatf("v%0d_fwd_valid", i), fwd_valid, vecs[i].wreg);
      check($sformatf("v%0d_fwd_dv", i), fwd_data_valid, 1'b1);
      check($sformatf("v%0d_fwd_wdata", i), fwd_wdata, vecs[i].e_wb_wdata);
      @(posedge clk); #1;
      ex_valid = 1'b0; advance = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_wb_valid", i), wb_valid, 1'b1);
      check($sformatf("v%0d_wb_wreg", i), wb_wreg, vecs[i].e_wb_wreg);
      check($sformatf("v%0d_wb_waddr", i), wb_waddr, vecs[i].waddr);
      check($sformatf("v%0d_wb_wdata", i), wb_wdata, vecs[i].e_wb_wdata);
      @(posedge clk); #1;
    end

    // Loads: word, signed/unsigned byte, signed/unsigned half.
    drive_load(32'h1000_0004, 2'd2, 1'b0, 5'd3);
    wait_load_done("ld_word", 2, 32'h8765_4321, 32'h8765_4321, 5'd3);
    drive_load(32'h0000_0203, 2'd0, 1'b0, 5'd4);
    wait_load_done("ld_sbyte", 1, 32'h80FF_FFFF, 32'hFFFF_FF80, 5'd4);
    drive_load(32'h0000_0203, 2'd0, 1'b1, 5'd6);
    wait_load_done("ld_ubyte", 1, 32'h80FF_FFFF, 32'h0000_0080, 5'd6);
    drive_load(32'h0000_0302, 2'd1, 1'b0, 5'd8);
    wait_load_done("ld_shalf", 3, 32'h9ABC_0000, 32'hFFFF_9ABC, 5'd8);
    drive_load(32'h0000_0300, 2'd1, 1'b1, 5'd9);
    wait_load_done("ld_uhalf", 1, 32'h1111_F00F, 32'h0000_F00F, 5'd9);

    // Half store with DCache not ready for three cycles.
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_size = 2'd1; ex_unsigned = 1'b0;
    ex_addr = 32'h0000_0802; ex_store_data = 32'h0000_BEEF; ex_excp = 1'b0; ex_wreg = 1'b0;
    ex_waddr = 5'd0; ex_wdata = 32'h77; advance = 1'b0; dcache_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("sth_c%0d_req_valid", c), dcache_req_valid, 1'b1);
      check($sformatf("sth_c%0d_wstrb", c), dcache_req_wstrb, 4'b1100);
      check($sformatf("sth_c%0d_wdata", c), dcache_req_wdata, 32'hBEEF_BEEF);
      check($sformatf("sth_c%0d_addr", c), dcache_req_addr, 32'h0000_0800);
      check($sformatf("sth_c%0d_adv_ready", c), advance_ready, 1'b0);
      @(posedge clk); #1;
    end
    dcache_req_ready = 1'b1;
    @(negedge clk);
    check("sth_acc_req_valid", dcache_req_valid, 1'b1);
    check("sth_acc_adv_ready", advance_ready, 1'b1);
    advance = 1'b1;
    @(posedge clk); #1;
    advance = 1'b0; ex_valid = 1'b0;
    @(negedge clk);
    check("sth_wb_valid", wb_valid, 1'b1);
    check("sth_wb_wreg", wb_wreg, 1'b0);
    check("sth_wb_wdata", wb_wdata, 32'h77);
    @(posedge clk); #1;

    // Flush while waiting: DRAIN swallows the response, next load issues after it.
    drive_load(32'h0000_0100, 2'd2, 1'b0, 5'd10);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive_load(32'h0000_0200, 2'd2, 1'b0, 5'd11);
    dcache_resp_valid = 1'b1; dcache_resp_data = 32'h0BAD_0BAD;
    @(negedge clk);
    check("drain_adv_ready", advance_ready, 1'b0);
    check("drain_req_valid", dcache_req_valid, 1'b0);
    check("drain_wb_valid", wb_valid, 1'b0);
    check("drain_wb_wdata", wb_wdata, 32'h0);
    @(posedge clk); #1;
    dcache_resp_valid = 1'b0;
    check("after_drain_req_addr", dcache_req_addr, 32'h0000_0200);
    wait_load_done("after_drain", 1, 32'h5566_7788, 32'h5566_7788, 5'd11);

    // Flush coinciding with the response returns straight to IDLE.
    drive_load(32'h0000_0300, 2'd2, 1'b0, 5'd12);
    @(posedge clk); #1;
    flush = 1'b1; dcache_resp_valid = 1'b1; dcache_resp_data = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    flush = 1'b0; dcache_resp_valid = 1'b0;
    drive_load(32'h0000_0340, 2'd2, 1'b0, 5'd13);
    wait_load_done("flush_resp", 2, 32'h0102_0304, 32'h0102_0304, 5'd13);

    // Reset in the middle of a load.
    drive_load(32'h0000_0500, 2'd2, 1'b0, 5'd14);
    @(posedge clk); #1;
    rst = 1'b1; ex_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_wb_valid", wb_valid, 1'b0);
    check("midrst_adv_ready", advance_ready, 1'b1);
    check("midrst_req_valid", dcache_req_valid, 1'b0);
    @(posedge clk); #1;
    drive_load(32'h0000_0600, 2'd2, 1'b0, 5'd15);
    wait_load_done("midrst_ld", 1, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 5'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage directly downstream of EX. It consumes the registered EX result and issues at most one DCache request per load or store. It waits for load data, then aligns and sign- or zero-extends it. It presents a registered write-back result and a forwarding tap to dispatch, and stalls the pipeline through `advance_ready` while a DCache access is pending.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `flush` in 1: discard the current instruction
- `advance` in 1: ctrl moves the pipeline this cycle
- `advance_ready` out 1: stage can complete this cycle
- `ex_valid` in 1: EX buffer holds a valid instruction
- `ex_load` in 1: instruction is a load
- `ex_store` in 1: instruction is a store
- `ex_size` in 2: access size; 0 = byte, 1 = half, 2 = word
- `ex_unsigned` in 1: zero-extend load data
- `ex_addr` in 32: physical access address
- `ex_store_data` in 32: store source register value
- `ex_excp` in 1: instruction already carries an exception
- `ex_wreg` in 1: register write enable
- `ex_waddr` in 5: register write address
- `ex_wdata` in 32: non-load result
- `dcache_req_valid` out 1: DCache request valid
- `dcache_req_ready` in 1: DCache accepts the request
- `dcache_req_we` out 1: request is a store
- `dcache_req_addr` out 32: `{ex_addr[31:2], 2'b00}`
- `dcache_req_wstrb` out 4: byte enables
- `dcache_req_wdata` out 32: lane-replicated store data
- `dcache_resp_valid` in 1: load data returned
- `dcache_resp_data` in 32: raw load word
- `wb_valid` out 1: registered, to WB
- `wb_wreg` out 1: registered, to WB
- `wb_waddr` out 5: registered, to WB
- `wb_wdata` out 32: registered, to WB
- `fwd_valid` out 1: forwarding tap to dispatch, `ex_valid & ex_wreg`
- `fwd_data_valid` out 1: forwarded data is final
- `fwd_waddr` out 5: forwarding address
- `fwd_wdata` out 32: forwarding data

## Operation
- `mem_op = ex_valid & (ex_load | ex_store) & ~ex_excp`.
  - Instructions with `ex_excp` set pass through without any DCache request.
- FSM states: IDLE, REQ, WAIT_RESP, DONE, DRAIN. Reset state is IDLE.
- IDLE:
  - If `mem_op`, assert `dcache_req_valid` combinationally this cycle.
  - Accepted store → DONE, or stay in IDLE if `advance` is high the same cycle.
  - Accepted load → WAIT_RESP.
  - Not accepted → REQ.
- REQ: hold the request with stable fields until accepted, then transition as from IDLE.
- WAIT_RESP: on `dcache_resp_valid`, capture the aligned data into `load_hold` → DONE, or → IDLE if `advance` (bypass only).
- DONE: `advance_ready = 1`; `advance` → IDLE.
- DRAIN:
  - `dcache_req_valid = 0` and `advance_ready = 0`.
  - On `dcache_resp_valid`, discard the data → IDLE.
- `advance_ready` is 1 when any of the following holds:
  - not `mem_op`;
  - state is DONE;
  - a store is accepted this cycle;
  - a load response arrives in WAIT_RESP (bypass only).
- Store write strobes:
  - byte: `4'b0001 << addr[1:0]`
  - half: `4'b0011 << {addr[1], 1'b0}`
  - word: `4'hF`
- Store write data: byte replicated ×4, half replicated ×2, word as-is.
- Load alignment: select the byte at `addr[1:0]` or the half at `addr[1]`, then sign- or zero-extend per `ex_unsigned`.
- Result selection: `result = ex_load & ~ex_excp ? load data : ex_wdata`.
- On `advance & ~flush`:
  - `wb_valid <= ex_valid`
  - `wb_wreg <= ex_wreg & ~ex_excp`
  - `wb_waddr <= ex_waddr`
  - `wb_wdata <= result`
- Forwarding: `fwd_data_valid = ~ex_load | ex_excp | (load data available this cycle)`.
- Flush:
  - IDLE, REQ, DONE → IDLE. An unaccepted request may be withdrawn.
  - WAIT_RESP → DRAIN.
  - All WB outputs cleared next cycle.
  - Flush has priority over a simultaneous `advance`.
  - A `dcache_resp_valid` arriving in the same cycle as the flush → IDLE directly.

## Timing
- Reset values: `wb_*` = 0, state = IDLE.
  - All DCache request outputs are 0 while `ex_valid` is 0.
  - `advance_ready` is 1 while `ex_valid` is 0.
- Store with `req_ready` held high: completes in the issue cycle (0 stall cycles).
- Load with a response N cycles after acceptance:
  - bypass build: `advance_ready` high in the response cycle;
  - non-bypass build: one cycle later.
- At most one outstanding DCache request. No new request is issued in WAIT_RESP or DRAIN.
- `dcache_resp_valid` outside WAIT_RESP and DRAIN is ignored.
- Mid-operation reset: FSM goes to IDLE immediately. Any in-flight response is the DCache's responsibility, since the DCache is also in reset.

## Configuration
- `MEM_LOAD_BYPASS_EN` defined:
  - the response-cycle result is muxed straight to `wb_wdata`'s D input and to `fwd_wdata`;
  - `advance_ready` rises in the response cycle.
- Not defined:
  - load data is always registered into `load_hold` first;
  - the path WAIT_RESP → DONE → advance adds 1 cycle, which shortens the timing path.

## Test plan
- **Word load:** `ex_addr` = 0x1000_0004, size 2; DCache returns 0x8765_4321 two cycles later → `wb_wdata` = 0x8765_4321. Stall is 2 cycles (bypass) or 3 cycles (non-bypass).
- **Signed byte load:** `ex_addr` = 0x…03, `ex_unsigned` = 0, resp 0x80FF_FFFF → `wb_wdata` = 0xFFFF_FF80. Same with `ex_unsigned` = 1 → 0x0000_0080.
- **Half store with stalled DCache:** `ex_addr` = 0x…02, data 0x0000_BEEF, `req_ready` low for 3 cycles:
  - wstrb = 4'b1100 and wdata = 0xBEEF_BEEF, held stable for 3 cycles;
  - `advance_ready` rises on the acceptance cycle.
- **Flush in WAIT_RESP:** response 2 cycles later → DRAIN, `advance_ready` = 0. Response discarded, `wb_valid` = 0, next load issues the cycle after the response.
- **Excepted load:** `ex_excp` = 1 → no `dcache_req_valid`, `advance_ready` = 1, `wb_wreg` = 0.
- **Non-memory instruction:** `ex_wdata` = 0x1234, `ex_wreg` = 1 → `fwd_data_valid` = 1, `fwd_wdata` = 0x1234, `wb_wdata` = 0x1234 the cycle after `advance`.
